// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// Contents:
//   DEFAULT_WIDTH - default operand/result width
//   state_t       - controller state encoding (IDLE, RUN, FINISH)
//   cnt_width()   - width of the iteration counter for a given operand width
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_t;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the control unit and the divider.
// Signals:
//   start       - request, sampled only while the divider is idle
//   is_signed   - 1 = DIV (two's complement), 0 = DIVU; sampled with start
//   src_a       - dividend; sampled with start
//   src_b       - divisor; sampled with start
//   busy        - an operation is in progress
//   done        - one-cycle pulse, results valid from this cycle
//   div_by_zero - valid with done, set if the divisor was zero
//   quotient    - registered quotient (to LO)
//   remainder   - registered remainder (to HI)
// Modports: master (requester side) and slave (the divider).
interface div_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, src_a, src_b,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, is_signed, src_a, src_b,
        output busy, done, div_by_zero, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in   - partial remainder R (always smaller than the divisor)
//   quo_in   - quotient/dividend shift register Q
//   divisor  - divisor magnitude D
//   rem_out  - next R
//   quo_out  - next Q with the new quotient bit in bit 0
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // {R,Q} shifted left by one; the top dividend bit moves into R.
    // Because R < D before the shift, the shifted value needs WIDTH+1 bits
    // and a successful subtraction always leaves a result below D.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = (shifted >= {1'b0, divisor});

    assign rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider backing the MIPS DIV/DIVU instructions.
// One quotient bit is produced per clock; signed division works on operand
// magnitudes and fixes up the signs when the result is registered.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, discards any in-flight operation
//   bus   - div_if slave: start/is_signed/src_a/src_b in,
//           busy/done/div_by_zero/quotient/remainder out
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;

    logic             done_q;
    logic             div_by_zero_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             accept;
    logic             finish_now;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // Negating the most-negative value yields the same bit pattern, which
    // read as unsigned is exactly its magnitude, so no extra bit is needed.
    assign a_neg  = bus.is_signed & bus.src_a[WIDTH-1];
    assign b_neg  = bus.is_signed & bus.src_b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag  = b_neg ? -bus.src_b : bus.src_b;
    assign b_zero = (bus.src_b == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new request is only taken in IDLE once the done pulse has gone, so a
    // start held through the done cycle is not mistaken for a fresh one.
    // FINISH stays put while the counter is non-zero: a normal divide enters
    // it with the counter already at zero, a zero divisor enters with one so
    // its result lands two edges after the start edge.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !done_q) begin
                    accept  = 1'b1;
                    state_d = b_zero ? FINISH : RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign finish_now = (state_q == FINISH) && (cnt_q == '0);

    // For a zero divisor the dividend magnitude stays parked in quo_q; with
    // rneg applied it reproduces the original dividend as the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            dz_q          <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
        end else begin
            done_q <= finish_now;
            if (accept) begin
                rem_q         <= '0;
                quo_q         <= a_mag;
                dvsr_q        <= b_mag;
                qneg_q        <= a_neg ^ b_neg;
                rneg_q        <= a_neg;
                dz_q          <= b_zero;
                cnt_q         <= b_zero ? CNT_W'(1) : CNT_W'(WIDTH);
                div_by_zero_q <= 1'b0;
            end else if (state_q == RUN) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - 1'b1;
            end else if ((state_q == FINISH) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (finish_now) begin
                div_by_zero_q <= dz_q;
                if (dz_q) begin
                    quotient_q  <= '1;
                    remainder_q <= rneg_q ? -quo_q : quo_q;
                end else begin
                    quotient_q  <= qneg_q ? -quo_q : quo_q;
                    remainder_q <= rneg_q ? -rem_q : rem_q;
                end
            end
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;

endmodule
